// File: rtl/axis_tx_frame_arbiter.sv
// axis_tx_frame_arbiter
// Frame-granular round-robin arbiter feeding one AXI-Stream MAC input from
// S_COUNT byte-wide frame sources. A grant is held from the first beat of a
// frame through its tlast; frames longer than MAX_FRAME_LEN are cut short,
// marked bad, and the remainder of the source frame is drained.
module axis_tx_frame_arbiter #(
  parameter int S_COUNT       = 4,
  parameter int MAX_FRAME_LEN = 1518
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [S_COUNT*8-1:0] s_axis_tdata,
  input  logic [S_COUNT-1:0]   s_axis_tvalid,
  output logic [S_COUNT-1:0]   s_axis_tready,
  input  logic [S_COUNT-1:0]   s_axis_tlast,
  input  logic [S_COUNT-1:0]   s_axis_tuser,
  output logic [7:0]           m_axis_tdata,
  output logic                 m_axis_tvalid,
  input  logic                 m_axis_tready,
  output logic                 m_axis_tlast,
  output logic                 m_axis_tuser,
  output logic [S_COUNT-1:0]   grant,
  output logic                 grant_valid,
  output logic                 frame_truncated
);

  localparam int IW = (S_COUNT > 1) ? $clog2(S_COUNT) : 1;
  // Beat counter value while the final permitted beat is on the bus.
  localparam logic [15:0] LAST_BEAT_CNT = 16'(MAX_FRAME_LEN - 1);

  typedef enum logic [1:0] {IDLE, XFER, DROP} state_t;

  state_t             state_reg, state_next;
  logic [S_COUNT-1:0] grant_reg, grant_next;
  logic [IW-1:0]      last_grant_reg, last_grant_next;
  logic [15:0]        beat_cnt_reg, beat_cnt_next;
  logic               trunc_reg, trunc_next;

  // Granted-port view of the slave bus (all zero when nothing is granted).
  logic [7:0]         sel_data;
  logic               sel_valid;
  logic               sel_last;
  logic               sel_user;

  // Round-robin pick: ports above the last winner take precedence, otherwise
  // wrap around to the lowest-numbered requester.
  logic [S_COUNT-1:0] above_last;
  logic [S_COUNT-1:0] req_masked;
  logic [IW-1:0]      pick_idx;
  logic               at_limit;

  genvar gi;
  generate
    for (gi = 0; gi < S_COUNT; gi++) begin : g_mask
      assign above_last[gi] = (IW'(gi) > last_grant_reg);
    end
  endgenerate

  assign req_masked = s_axis_tvalid & above_last;
  assign at_limit   = (beat_cnt_reg == LAST_BEAT_CNT);

  // Priority encoder over the masked and unmasked request vectors.
  always_comb begin
    pick_idx = '0;
    for (int i = S_COUNT - 1; i >= 0; i--) begin
      if (s_axis_tvalid[i]) pick_idx = IW'(i);
    end
    for (int i = S_COUNT - 1; i >= 0; i--) begin
      if (req_masked[i]) pick_idx = IW'(i);
    end
  end

  // One-hot mux of the granted source's beat.
  always_comb begin
    sel_data  = '0;
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_user  = 1'b0;
    for (int i = 0; i < S_COUNT; i++) begin
      if (grant_reg[i]) begin
        sel_data  = s_axis_tdata[8*i +: 8];
        sel_valid = s_axis_tvalid[i];
        sel_last  = s_axis_tlast[i];
        sel_user  = s_axis_tuser[i];
      end
    end
  end

  // Next-state and output decode for the arbitration FSM.
  always_comb begin
    state_next      = state_reg;
    grant_next      = grant_reg;
    last_grant_next = last_grant_reg;
    beat_cnt_next   = beat_cnt_reg;
    trunc_next      = 1'b0;
    s_axis_tready   = '0;
    m_axis_tvalid   = 1'b0;
    m_axis_tdata    = '0;
    m_axis_tlast    = 1'b0;
    m_axis_tuser    = 1'b0;

    case (state_reg)
      IDLE: begin
        if (|s_axis_tvalid) begin
          grant_next      = S_COUNT'(1) << pick_idx;
          last_grant_next = pick_idx;
          beat_cnt_next   = '0;
          state_next      = XFER;
        end
      end

      XFER: begin
        m_axis_tvalid = sel_valid;
        m_axis_tdata  = sel_data;
        // The final permitted beat is forced to end the frame and flag it bad,
        // unless the source itself ends the frame exactly there.
        m_axis_tlast  = sel_last | at_limit;
        m_axis_tuser  = sel_user | (at_limit & ~sel_last);
        s_axis_tready = grant_reg & {S_COUNT{m_axis_tready}};
        if (sel_valid && m_axis_tready) begin
          beat_cnt_next = beat_cnt_reg + 16'd1;
          if (sel_last) begin
            state_next = IDLE;
            grant_next = '0;
          end else if (at_limit) begin
            state_next = DROP;
            trunc_next = 1'b1;
          end
        end
      end

      DROP: begin
        // Swallow the rest of the oversized source frame.
        s_axis_tready = grant_reg;
        if (sel_valid && sel_last) begin
          state_next = IDLE;
          grant_next = '0;
        end
      end

      default: begin
        state_next = IDLE;
        grant_next = '0;
      end
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      grant_reg      <= '0;
      last_grant_reg <= IW'(S_COUNT - 1);
      beat_cnt_reg   <= '0;
      trunc_reg      <= 1'b0;
    end else begin
      state_reg      <= state_next;
      grant_reg      <= grant_next;
      last_grant_reg <= last_grant_next;
      beat_cnt_reg   <= beat_cnt_next;
      trunc_reg      <= trunc_next;
    end
  end

  assign grant           = grant_reg;
  assign grant_valid     = (state_reg != IDLE);
  assign frame_truncated = trunc_reg;

endmodule

// File: tb/tb_axis_tx_frame_arbiter.sv
// Testbench for axis_tx_frame_arbiter: a directed vector table, hand-written
// corner sequences, and randomized traffic checked against a frame-queue model.
module tb_axis_tx_frame_arbiter;

  localparam int S   = 4;
  localparam int MAX = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [S*8-1:0] s_tdata = '0;
  logic [S-1:0] s_tvalid = '0;
  logic [S-1:0] s_tready;
  logic [S-1:0] s_tlast = '0;
  logic [S-1:0] s_tuser = '0;
  logic [7:0]   m_tdata;
  logic         m_tvalid;
  logic         m_tready = 1'b0;
  logic         m_tlast;
  logic         m_tuser;
  logic [S-1:0] grant;
  logic         grant_valid;
  logic         frame_truncated;

  always #5 clk = ~clk;

  axis_tx_frame_arbiter #(.S_COUNT(S), .MAX_FRAME_LEN(MAX)) dut (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready),
    .s_axis_tlast(s_tlast), .s_axis_tuser(s_tuser),
    .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready),
    .m_axis_tlast(m_tlast), .m_axis_tuser(m_tuser),
    .grant(grant), .grant_valid(grant_valid), .frame_truncated(frame_truncated)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    bit         rst;
    logic [3:0] tv, tl, tu;
    logic [31:0] td;
    bit         mr;
    logic [3:0] e_grant;
    bit         e_gv, e_mv, e_ml, e_mu;
    logic [7:0] e_md;
    logic [3:0] e_sr;
    bit         e_tr;
  } vec_t;

  vec_t vecs[10];

  // ---------------- source + reference model ----------------
  typedef struct packed {logic [7:0] data; logic last; logic user;} beat_t;

  beat_t src_q[S][$];
  bit    pres[S];
  bit    rand_valid = 1'b0;
  int    ready_mode = 0;
  int    cyc = 0;

  // Model: which frame is in flight, how many beats it has delivered.
  int md_phase;  // 0 waiting for a request, 1 forwarding, 2 discarding
  int md_port;
  int md_last;
  int md_cnt;
  bit md_trunc;

  int mon_beats, mon_trunc, mon_frame_len;
  bit prev_gv;
  int dut_order[$];

  task automatic model_reset();
    md_phase = 0; md_port = 0; md_last = S - 1; md_cnt = 0; md_trunc = 1'b0;
    prev_gv = 1'b0; mon_frame_len = 0;
  endtask

  task automatic add_frame(input int p, input int len, input bit user, input logic [7:0] base);
    for (int k = 0; k < len; k++) begin
      beat_t b;
      b.data = base + 8'(k);
      b.last = (k == len - 1);
      b.user = user;
      src_q[p].push_back(b);
    end
  endtask

  function automatic int onehot_idx(input logic [S-1:0] v);
    int r = -1;
    for (int i = 0; i < S; i++) if (v[i]) r = i;
    return r;
  endfunction

  task automatic step(input bit do_rst);
    logic [3:0] e_grant, e_sr;
    bit e_gv, e_mv, e_ml, e_mu, trunc_n;
    logic [7:0] e_md;
    beat_t hd;
    int p;
    @(posedge clk); #1;
    cyc++;
    for (int i = 0; i < S; i++)
      if (!pres[i] && src_q[i].size() > 0 && (!rand_valid || $urandom_range(0, 3) != 0))
        pres[i] = 1'b1;
    s_tvalid = '0; s_tdata = '0; s_tlast = '0; s_tuser = '0;
    for (int i = 0; i < S; i++) begin
      if (pres[i]) begin
        hd = src_q[i][0];
        s_tvalid[i] = 1'b1;
        s_tdata[8*i +: 8] = hd.data;
        s_tlast[i] = hd.last;
        s_tuser[i] = hd.user;
      end
    end
    case (ready_mode)
      0: m_tready = 1'b1;
      1: m_tready = ($urandom_range(0, 2) != 0);
      default: m_tready = (cyc % 3 == 0);
    endcase
    rst = do_rst;
    @(negedge clk);

    // expected outputs for this cycle
    e_grant = '0; e_sr = '0; e_gv = 0; e_mv = 0; e_ml = 0; e_mu = 0; e_md = '0;
    p = md_port;
    if (md_phase == 1) begin
      e_grant = 4'(1 << p); e_gv = 1;
      e_mv = pres[p];
      e_sr = m_tready ? 4'(1 << p) : 4'b0;
      if (e_mv) begin
        hd = src_q[p][0];
        e_md = hd.data;
        e_ml = hd.last || (md_cnt == MAX - 1);
        e_mu = hd.user || ((md_cnt == MAX - 1) && !hd.last);
      end
    end else if (md_phase == 2) begin
      e_grant = 4'(1 << p); e_gv = 1; e_sr = 4'(1 << p);
    end
    chk("grant", grant, e_grant);
    chk("grant_valid", grant_valid, e_gv);
    chk("m_tvalid", m_tvalid, e_mv);
    chk("s_tready", s_tready, e_sr);
    chk("frame_truncated", frame_truncated, md_trunc);
    if (e_mv || md_phase == 0) begin
      chk("m_tdata", m_tdata, e_md);
      chk("m_tlast", m_tlast, e_ml);
      chk("m_tuser", m_tuser, e_mu);
    end

    // monitor of what the DUT actually delivered
    if (frame_truncated) mon_trunc++;
    if (grant_valid && !prev_gv) dut_order.push_back(onehot_idx(grant));
    prev_gv = grant_valid;
    if (m_tvalid && m_tready) begin
      mon_beats++;
      mon_frame_len++;
      if (m_tlast) begin
        $display("frame: port=%0d beats=%0d tuser=%0d cycle=%0d", onehot_idx(grant), mon_frame_len, m_tuser, cyc);
        mon_frame_len = 0;
      end
    end

    // advance sources and model
    if (do_rst) begin
      for (int i = 0; i < S; i++) begin src_q[i].delete(); pres[i] = 1'b0; end
      model_reset();
    end else begin
      trunc_n = 1'b0;
      case (md_phase)
        0: begin
          for (int k = S; k >= 1; k--) begin
            if (pres[(md_last + k) % S]) md_port = (md_last + k) % S;
          end
          if (pres[0] || pres[1] || pres[2] || pres[3]) begin
            md_last = md_port; md_cnt = 0; md_phase = 1;
          end
        end
        1: if (pres[p] && m_tready) begin
          hd = src_q[p].pop_front(); pres[p] = 1'b0;
          if (hd.last) md_phase = 0;
          else if (md_cnt == MAX - 1) begin md_phase = 2; trunc_n = 1'b1; end
          md_cnt++;
        end
        default: if (pres[p]) begin
          hd = src_q[p].pop_front(); pres[p] = 1'b0;
          if (hd.last) md_phase = 0;
        end
      endcase
      md_trunc = trunc_n;
    end
  endtask

  initial begin
    //          rst tv    tl    tu    td            mr grant gv mv ml mu md     sr    tr
    vecs[0] = '{1, 4'h0, 4'h0, 4'h0, 32'h0,        1, 4'h0, 0, 0, 0, 0, 8'h00, 4'h0, 0};
    vecs[1] = '{0, 4'h2, 4'h0, 4'h0, 32'h00001100, 1, 4'h0, 0, 0, 0, 0, 8'h00, 4'h0, 0};
    vecs[2] = '{0, 4'h2, 4'h0, 4'h0, 32'h00001100, 1, 4'h2, 1, 1, 0, 0, 8'h11, 4'h2, 0};
    vecs[3] = '{0, 4'h2, 4'h0, 4'h0, 32'h00002200, 1, 4'h2, 1, 1, 0, 0, 8'h22, 4'h2, 0};
    vecs[4] = '{0, 4'h2, 4'h2, 4'h0, 32'h00003300, 1, 4'h2, 1, 1, 1, 0, 8'h33, 4'h2, 0};
    vecs[5] = '{0, 4'h0, 4'h0, 4'h0, 32'h0,        1, 4'h0, 0, 0, 0, 0, 8'h00, 4'h0, 0};
    vecs[6] = '{0, 4'h8, 4'h8, 4'h8, 32'hAA000000, 0, 4'h0, 0, 0, 0, 0, 8'h00, 4'h0, 0};
    vecs[7] = '{0, 4'h8, 4'h8, 4'h8, 32'hAA000000, 0, 4'h8, 1, 1, 1, 1, 8'hAA, 4'h0, 0};
    vecs[8] = '{0, 4'h8, 4'h8, 4'h8, 32'hAA000000, 1, 4'h8, 1, 1, 1, 1, 8'hAA, 4'h8, 0};
    vecs[9] = '{0, 4'h0, 4'h0, 4'h0, 32'h0,        1, 4'h0, 0, 0, 0, 0, 8'h00, 4'h0, 0};

    for (int i = 0; i < S; i++) pres[i] = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);

    // directed vectors
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      rst = vecs[i].rst; s_tvalid = vecs[i].tv; s_tlast = vecs[i].tl;
      s_tuser = vecs[i].tu; s_tdata = vecs[i].td; m_tready = vecs[i].mr;
      @(negedge clk);
      chk($sformatf("v%0d_grant", i), grant, vecs[i].e_grant);
      chk($sformatf("v%0d_gv", i), grant_valid, vecs[i].e_gv);
      chk($sformatf("v%0d_mvalid", i), m_tvalid, vecs[i].e_mv);
      chk($sformatf("v%0d_mlast", i), m_tlast, vecs[i].e_ml);
      chk($sformatf("v%0d_muser", i), m_tuser, vecs[i].e_mu);
      chk($sformatf("v%0d_mdata", i), m_tdata, vecs[i].e_md);
      chk($sformatf("v%0d_sready", i), s_tready, vecs[i].e_sr);
      chk($sformatf("v%0d_trunc", i), frame_truncated, vecs[i].e_tr);
      $display("vector %0d applied", i);
    end
    @(posedge clk); #1;
    rst = 1'b1; s_tvalid = '0; s_tlast = '0; s_tuser = '0; s_tdata = '0;
    model_reset();

    // round robin between ports 0 and 1
    add_frame(0, 2, 0, 8'h00); add_frame(0, 2, 0, 8'h10);
    add_frame(1, 2, 0, 8'h20); add_frame(1, 2, 0, 8'h30);
    dut_order.delete();
    repeat (20) step(0);
    chk("rr_count", dut_order.size(), 4);
    for (int i = 0; i < 4; i++)
      chk($sformatf("rr_order%0d", i), (dut_order.size() > i) ? dut_order[i] : 99, i % 2);

    // single active port is regranted each frame
    add_frame(2, 1, 0, 8'h50); add_frame(2, 3, 1, 8'h60); add_frame(2, 2, 0, 8'h70);
    dut_order.delete();
    repeat (20) step(0);
    chk("p2_count", dut_order.size(), 3);
    for (int i = 0; i < 3; i++)
      chk($sformatf("p2_order%0d", i), (dut_order.size() > i) ? dut_order[i] : 99, 2);

    // truncation of a 20-beat frame
    mon_beats = 0; mon_trunc = 0;
    add_frame(3, 20, 0, 8'h80);
    repeat (30) step(0);
    chk("trunc_beats", mon_beats, MAX);
    chk("trunc_pulses", mon_trunc, 1);

    // backpressure pattern 1,0,0
    ready_mode = 2; mon_beats = 0;
    add_frame(0, 6, 0, 8'hC0);
    repeat (30) step(0);
    chk("bp_beats", mon_beats, 6);
    ready_mode = 0;

    // reset during beat 5 of a 10-beat frame, then priority restarts at port 0
    add_frame(0, 10, 0, 8'hD0);
    for (int n = 0; n < 40 && !(md_phase == 1 && md_cnt == 4); n++) step(0);
    chk("rst_at_beat5", md_cnt, 4);
    step(1);
    step(0);
    add_frame(3, 2, 0, 8'hE0); add_frame(0, 2, 0, 8'hF0);
    dut_order.delete();
    repeat (12) step(0);
    chk("rst_prio", (dut_order.size() > 0) ? dut_order[0] : 99, 0);

    // randomized traffic
    rand_valid = 1'b1; ready_mode = 1; mon_trunc = 0;
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < S; i++)
        if (src_q[i].size() == 0 && $urandom_range(0, 7) == 0)
          add_frame(i, $urandom_range(1, 22), ($urandom_range(0, 3) == 0), 8'($urandom));
      step(0);
    end
    rand_valid = 1'b0; ready_mode = 0;
    repeat (200) step(0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
